// File: rtl/condicionador_jogada.sv
// condicionador_jogada: synchronizes, debounces and one-hot-filters the raw button vector,
// emitting one tem_jogada pulse per physical press and requiring full release to re-arm.
module condicionador_jogada #(
   parameter int DEBOUNCE_CICLOS = 20,
   parameter int LARGURA_CNT     = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes,
   output logic [3:0] jogada,
   output logic       tem_jogada,
   output logic       jogada_invalida,
   output logic [2:0] db_estado
);
   typedef enum logic [2:0] {
      ESPERA   = 3'b000,
      FILTRA   = 3'b001,
      REGISTRA = 3'b010,
      INVALIDA = 3'b011,
      SOLTA    = 3'b100
   } estado_t;
   localparam logic [LARGURA_CNT-1:0] FIM = LARGURA_CNT'(DEBOUNCE_CICLOS - 1);
   estado_t r_estado, w_prox;
   logic [3:0] r_sync1, r_sync2, r_cand, w_cand, r_jogada;
   logic [LARGURA_CNT-1:0] r_cnt, w_cnt;
   logic w_fim, w_onehot;
   assign w_fim    = r_cnt == FIM;
   assign w_onehot = (r_cand != 4'd0) && ((r_cand & (r_cand - 4'd1)) == 4'd0);
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_estado <= ESPERA;
         r_cnt    <= '0;
         r_cand   <= '0;
         r_jogada <= '0;
      end else begin
         r_sync1  <= botoes;
         r_sync2  <= r_sync1;
         r_estado <= w_prox;
         r_cnt    <= w_cnt;
         r_cand   <= w_cand;
         if (r_estado == FILTRA && w_prox == REGISTRA) r_jogada <= r_cand;
      end
   end
   always_comb begin
      w_prox = r_estado;
      w_cnt  = r_cnt;
      w_cand = r_cand;
      case (r_estado)
         ESPERA:
            if (r_sync2 != 4'd0) begin
               w_cand = r_sync2;
               w_cnt  = '0;
               w_prox = FILTRA;
            end
         FILTRA:
            if (r_sync2 != r_cand) begin
               if (r_sync2 == 4'd0) w_prox = ESPERA;
               else begin
                  w_cand = r_sync2;
                  w_cnt  = '0;
               end
            end else if (w_fim) w_prox = w_onehot ? REGISTRA : INVALIDA;
            else w_cnt = r_cnt + 1'b1;
         REGISTRA, INVALIDA: begin
            w_prox = SOLTA;
            w_cnt  = '0;
         end
         SOLTA:
            if (r_sync2 != 4'd0) w_cnt = '0;
            else if (w_fim) w_prox = ESPERA;
            else w_cnt = r_cnt + 1'b1;
         default: w_prox = ESPERA;
      endcase
   end
   always_comb begin
      jogada          = r_jogada;
      tem_jogada      = r_estado == REGISTRA;
      jogada_invalida = r_estado == INVALIDA;
      db_estado       = r_estado;
   end
endmodule
